// File: rtl/div_issue_ctrl_if.sv
// Operand/result AXI-stream bundle between the divide sequencer and the signed/unsigned divider cores.
// Operands are shared; each core has its own dividend/divisor channels and dout channel.
interface div_issue_ctrl_if #(
  parameter int W = 32
);
  logic [W-1:0]   op_dividend;
  logic [W-1:0]   op_divisor;

  logic           s_dvd_tvalid;
  logic           s_dvd_tready;
  logic           s_dvs_tvalid;
  logic           s_dvs_tready;
  logic           s_dout_tvalid;
  logic [2*W-1:0] s_dout_tdata;

  logic           u_dvd_tvalid;
  logic           u_dvd_tready;
  logic           u_dvs_tvalid;
  logic           u_dvs_tready;
  logic           u_dout_tvalid;
  logic [2*W-1:0] u_dout_tdata;

  modport master (
    output op_dividend, op_divisor,
    output s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid,
    input  s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
    input  u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata
  );

  modport slave (
    input  op_dividend, op_divisor,
    input  s_dvd_tvalid, s_dvs_tvalid, u_dvd_tvalid, u_dvs_tvalid,
    output s_dvd_tready, s_dvs_tready, s_dout_tvalid, s_dout_tdata,
    output u_dvd_tready, u_dvs_tready, u_dout_tvalid, u_dout_tdata
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// One-op-in-flight divide sequencer: tvalid the cycle after accept, done the cycle after dout.
// Operand tvalids hold until their own handshake; a flushed op is drained silently.
module div_issue_ctrl #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_src1,
  input  logic [W-1:0] req_src2,
  input  logic         flush,
  input  logic         res_ack,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  div_issue_ctrl_if.master core
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state, state_nxt;
  logic           sel_signed, sel_quot;
  logic           dvd_vld, dvs_vld;
  logic           kill;
  logic [W-1:0]   dividend_q, divisor_q, result_q;

  logic           accept;
  logic           dvd_rdy, dvs_rdy;
  logic           dout_vld;
  logic [2*W-1:0] dout_dat;

  assign accept   = (state == IDLE) & req_valid & (|req_op) & ~flush;
  assign dvd_rdy  = sel_signed ? core.s_dvd_tready  : core.u_dvd_tready;
  assign dvs_rdy  = sel_signed ? core.s_dvs_tready  : core.u_dvs_tready;
  assign dout_vld = sel_signed ? core.s_dout_tvalid : core.u_dout_tvalid;
  assign dout_dat = sel_signed ? core.s_dout_tdata  : core.u_dout_tdata;

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;

  assign core.op_dividend  = dividend_q;
  assign core.op_divisor   = divisor_q;
  assign core.s_dvd_tvalid = dvd_vld & sel_signed;
  assign core.s_dvs_tvalid = dvs_vld & sel_signed;
  assign core.u_dvd_tvalid = dvd_vld & ~sel_signed;
  assign core.u_dvs_tvalid = dvs_vld & ~sel_signed;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      // A channel already handshaken no longer gates the move to WAIT.
      ISSUE: if ((~dvd_vld | dvd_rdy) & (~dvs_vld | dvs_rdy)) state_nxt = WAIT;
      WAIT:  if (dout_vld) state_nxt = (kill | flush) ? IDLE : DONE;
      DONE:  if (res_ack | flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sel_signed <= 1'b0;
      sel_quot   <= 1'b0;
      dvd_vld    <= 1'b0;
      dvs_vld    <= 1'b0;
      kill       <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        dividend_q <= req_src1;
        divisor_q  <= req_src2;
        // Lowest set op bit wins on a multi-hot request.
        sel_signed <= req_op[0] | (~req_op[1] & req_op[2]);
        sel_quot   <= req_op[0] | req_op[1];
        dvd_vld    <= 1'b1;
        dvs_vld    <= 1'b1;
      end else begin
        if (dvd_vld & dvd_rdy) dvd_vld <= 1'b0;
        if (dvs_vld & dvs_rdy) dvs_vld <= 1'b0;
      end

      if (state_nxt == IDLE)
        kill <= 1'b0;
      else if (flush & ((state == ISSUE) | (state == WAIT)))
        kill <= 1'b1;

      if ((state == WAIT) & dout_vld & ~kill & ~flush)
        result_q <= sel_quot ? dout_dat[2*W-1:W] : dout_dat[W-1:0];
    end
  end

endmodule
